// File: rtl/vsram_pkg.sv
// Shared types and helpers for the vsram_mport multi-port SRAM model.
package vsram_pkg;

    localparam int MAX_PORTS = 4;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } vsram_state_t;

    // Highest-index set bit of a same-address hit mask; -1 when no port hits.
    function automatic int win_port(input logic [MAX_PORTS-1:0] hits);
        int w;
        w = -1;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (hits[i]) w = i;
        end
        return w;
    endfunction

endpackage

// File: rtl/vsram_rd_pipe.sv
// RD_LAT-deep read-data/valid delay line for one read port; the output word
// only advances when a valid word reaches it, so it holds between reads.
module vsram_rd_pipe
    import vsram_pkg::*;
#(
    parameter int WIDTH  = 48,
    parameter int RD_LAT = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [RD_LAT-1:0] vld;
    logic [WIDTH-1:0]  dat [RD_LAT];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= in_data;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[RD_LAT-1];
    assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/vsram_mport.sv
// Parametrised NW-write / NR-read SRAM with pipelined reads, highest-port-wins
// write arbitration and a post-reset clear sweep. Optional macro VSRAM_FWD_EN
// forwards a same-edge write to a read of the same address.
module vsram_mport
    import vsram_pkg::*;
#(
    parameter int               WIDTH      = 48,
    parameter int               DEPTH      = 512,
    parameter int               NW         = 2,
    parameter int               NR         = 2,
    parameter int               RD_LAT     = 1,
    parameter int               INIT_CLEAR = 1,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0,
    parameter string            MEM_FILE   = "",
    localparam int              AW         = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear_req,
    input  logic [NW-1:0]       we,
    input  logic [NW*AW-1:0]    wr_addr,
    input  logic [NW*WIDTH-1:0] wr_data,
    input  logic [NR-1:0]       re,
    input  logic [NR*AW-1:0]    rd_addr,
    output logic [NR*WIDTH-1:0] rd_data,
    output logic [NR-1:0]       rd_valid,
    output logic                busy,
    output logic                wr_collision
);

    // MEM_FILE names the preload image used by the memory-init flow when
    // INIT_CLEAR=0; this model starts IDLE in that case and reads no files.
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    vsram_state_t     state, state_nxt;
    logic [AW-1:0]    sweep_addr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wa   [NW];
    logic [WIDTH-1:0] wd   [NW];
    logic [NW-1:0]    wv;
    logic [NW-1:0]    win;
    logic             coll;
    logic [AW-1:0]    ra   [NR];
    logic [WIDTH-1:0] rdat [NR];
    logic [NR-1:0]    rvld;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clear_req)          state_nxt = ST_CLEAR;
            ST_CLEAR: if (sweep_addr == LAST) state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_CLEAR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  sweep_addr <= '0;
        else if (busy) sweep_addr <= (sweep_addr == LAST) ? '0 : sweep_addr + 1'b1;
        else           sweep_addr <= '0;
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        logic [MAX_PORTS-1:0] hits;
        hits = '0;
        coll = 1'b0;
        win  = '0;
        for (int k = 0; k < NW; k++) begin
            wa[k] = wr_addr[k*AW +: AW];
            wd[k] = wr_data[k*WIDTH +: WIDTH];
            wv[k] = we[k] && !busy && ({1'b0, wa[k]} < DEPTH_W);
        end
        for (int k = 0; k < NW; k++) begin
            hits = '0;
            for (int m = 0; m < NW; m++) begin
                if (wv[m] && (wa[m] == wa[k])) hits[m] = 1'b1;
            end
            win[k] = wv[k] && (win_port(hits) == k);
            if (wv[k] && !win[k]) coll = 1'b1;
        end
    end

    // NOTE: the array itself is never reset; only the clear sweep initialises it.
    always_ff @(posedge clock) begin
        if (busy) begin
            mem[sweep_addr] <= INIT_VAL;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (win[k]) mem[wa[k]] <= wd[k];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) wr_collision <= 1'b0;
        else          wr_collision <= coll;
    end

    // Array reads see pre-edge contents, giving old data on a same-edge write.
    always_comb begin
        for (int j = 0; j < NR; j++) begin
            ra[j]   = rd_addr[j*AW +: AW];
            rdat[j] = ({1'b0, ra[j]} < DEPTH_W) ? mem[ra[j]] : '0;
`ifdef VSRAM_FWD_EN
            for (int k = 0; k < NW; k++) begin
                if (win[k] && (wa[k] == ra[j])) rdat[j] = wd[k];
            end
`endif
        end
    end

    assign rvld = re & {NR{~busy}};

    for (genvar j = 0; j < NR; j++) begin : g_rd
        vsram_rd_pipe #(
            .WIDTH  (WIDTH),
            .RD_LAT (RD_LAT)
        ) u_pipe (
            .clock     (clock),
            .reset_n   (reset_n),
            .in_valid  (rvld[j]),
            .in_data   (rdat[j]),
            .out_valid (rd_valid[j]),
            .out_data  (rd_data[j*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_vsram_mport.sv
// Directed bench for vsram_mport: instance A uses the defaults, instance B is
// DEPTH=300, RD_LAT=3, one port each way.
module tb_vsram_mport;

    localparam int W  = 48;
    localparam int AW = 9;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic          clear_req_a, busy_a, wr_collision_a;
    logic [1:0]    we_a, re_a, rd_valid_a;
    logic [2*AW-1:0] wr_addr_a, rd_addr_a;
    logic [2*W-1:0]  wr_data_a, rd_data_a;

    logic          clear_req_b, busy_b, wr_collision_b;
    logic [0:0]    we_b, re_b, rd_valid_b;
    logic [AW-1:0] wr_addr_b, rd_addr_b;
    logic [W-1:0]  wr_data_b, rd_data_b;

    vsram_mport u_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_req    (clear_req_a),
        .we           (we_a),
        .wr_addr      (wr_addr_a),
        .wr_data      (wr_data_a),
        .re           (re_a),
        .rd_addr      (rd_addr_a),
        .rd_data      (rd_data_a),
        .rd_valid     (rd_valid_a),
        .busy         (busy_a),
        .wr_collision (wr_collision_a)
    );

    vsram_mport #(.DEPTH(300), .NW(1), .NR(1), .RD_LAT(3)) u_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_req    (clear_req_b),
        .we           (we_b),
        .wr_addr      (wr_addr_b),
        .wr_data      (wr_data_b),
        .re           (re_b),
        .rd_addr      (rd_addr_b),
        .rd_data      (rd_data_b),
        .rd_valid     (rd_valid_b),
        .busy         (busy_b),
        .wr_collision (wr_collision_b)
    );

    int tests = 0;
    int fails = 0;
    int n_a, n_b, guard;

`ifdef VSRAM_FWD_EN
    localparam logic [W-1:0] T3_EXP = 48'h1234_5678_9ABC;
`else
    localparam logic [W-1:0] T3_EXP = 48'h0000_0000_BEEF;
`endif

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic count_sweep;
        n_a = 0; n_b = 0; guard = 0;
        while ((busy_a || busy_b) && guard < 2000) begin
            guard++;
            if (busy_a) n_a++;
            if (busy_b) n_b++;
            tick();
        end
    endtask

    task automatic write_a(input int port, input logic [AW-1:0] addr, input logic [W-1:0] data);
        we_a[port] = 1'b1;
        wr_addr_a[port*AW +: AW] = addr;
        wr_data_a[port*W +: W]   = data;
        tick();
        we_a = '0;
    endtask

    task automatic read_a(input int port, input logic [AW-1:0] addr, input logic [W-1:0] exp,
                          input string name);
        re_a[port] = 1'b1;
        rd_addr_a[port*AW +: AW] = addr;
        tick();
        re_a = '0;
        check({name, "_vld"}, 64'(rd_valid_a), 64'(2'b01 << port));
        check(name, 64'(rd_data_a[port*W +: W]), 64'(exp));
    endtask

    task automatic write_b(input logic [AW-1:0] addr, input logic [W-1:0] data);
        we_b = 1'b1; wr_addr_b = addr; wr_data_b = data;
        tick();
        we_b = 1'b0;
    endtask

    task automatic read_b(input logic [AW-1:0] addr, input logic [W-1:0] exp, input string name);
        re_b = 1'b1; rd_addr_b = addr;
        tick();
        re_b = 1'b0;
        tick();
        check({name, "_early"}, 64'(rd_valid_b), 64'd0);
        tick();
        check({name, "_vld"}, 64'(rd_valid_b), 64'd1);
        check(name, 64'(rd_data_b), 64'(exp));
    endtask

    initial begin
        reset_n = 1'b0;
        clear_req_a = 1'b0; we_a = '0; re_a = '0;
        wr_addr_a = '0; wr_data_a = '0; rd_addr_a = '0;
        clear_req_b = 1'b0; we_b = '0; re_b = '0;
        wr_addr_b = '0; wr_data_b = '0; rd_addr_b = '0;
        repeat (3) tick();

        check("rst_busy_a", 64'(busy_a), 64'd1);
        check("rst_busy_b", 64'(busy_b), 64'd1);
        check("rst_vld_a",  64'(rd_valid_a), 64'd0);
        check("rst_data_a", 64'(rd_data_a[W-1:0]), 64'd0);
        check("rst_coll_a", 64'(wr_collision_a), 64'd0);

        // Test 1: sweep lengths, then the last word reads back cleared.
        reset_n = 1'b1;
        count_sweep();
        check("t1_busy_cycles_a", 64'(n_a), 64'd512);
        check("t1_busy_cycles_b", 64'(n_b), 64'd300);
        read_a(0, 9'h1FF, '0, "t1_rd_1ff");
        tick();
        check("t1_vld_drop", 64'(rd_valid_a), 64'd0);

        // Test 2: collision on 0x010, port 1 wins.
        we_a = 2'b11;
        wr_addr_a = {9'h010, 9'h010};
        wr_data_a = {48'h5555, 48'hAAAA};
        tick();
        we_a = '0;
        check("t2_coll", 64'(wr_collision_a), 64'd1);
        tick();
        check("t2_coll_end", 64'(wr_collision_a), 64'd0);
        read_a(1, 9'h010, 48'h5555, "t2_win");
        tick();
        check("t2_hold_vld", 64'(rd_valid_a), 64'd0);
        check("t2_hold_data", 64'(rd_data_a[W +: W]), 64'h5555);

        we_a = 2'b11;
        wr_addr_a = {9'h012, 9'h011};
        wr_data_a = {48'h2222, 48'h1111};
        tick();
        we_a = '0;
        check("t2_no_coll", 64'(wr_collision_a), 64'd0);
        re_a = 2'b11;
        rd_addr_a = {9'h012, 9'h011};
        tick();
        re_a = '0;
        check("t2_dual_vld", 64'(rd_valid_a), 64'd3);
        check("t2_dual_p0", 64'(rd_data_a[W-1:0]), 64'h1111);
        check("t2_dual_p1", 64'(rd_data_a[W +: W]), 64'h2222);

        // Test 3: same-edge write/read of 0x020.
        write_a(1, 9'h020, 48'hBEEF);
        we_a[0] = 1'b1;
        wr_addr_a[AW-1:0] = 9'h020;
        wr_data_a[W-1:0]  = 48'h1234_5678_9ABC;
        re_a[0] = 1'b1;
        rd_addr_a[AW-1:0] = 9'h020;
        tick();
        we_a = '0; re_a = '0;
        check("t3_same_edge_vld", 64'(rd_valid_a), 64'd1);
        check("t3_same_edge", 64'(rd_data_a[W-1:0]), 64'(T3_EXP));
        read_a(0, 9'h020, 48'h1234_5678_9ABC, "t3_after");

        // Test 4: RD_LAT=3 back-to-back reads of 1, 2, 3.
        write_b(9'd1, 48'h101);
        write_b(9'd2, 48'h202);
        write_b(9'd3, 48'h303);
        re_b = 1'b1; rd_addr_b = 9'd1;
        tick();
        check("t4_e0_vld", 64'(rd_valid_b), 64'd0);
        rd_addr_b = 9'd2;
        tick();
        check("t4_e1_vld", 64'(rd_valid_b), 64'd0);
        rd_addr_b = 9'd3;
        tick();
        check("t4_r1_vld", 64'(rd_valid_b), 64'd1);
        check("t4_r1", 64'(rd_data_b), 64'h101);
        re_b = 1'b0;
        tick();
        check("t4_r2_vld", 64'(rd_valid_b), 64'd1);
        check("t4_r2", 64'(rd_data_b), 64'h202);
        tick();
        check("t4_r3_vld", 64'(rd_valid_b), 64'd1);
        check("t4_r3", 64'(rd_data_b), 64'h303);
        tick();
        check("t4_end_vld", 64'(rd_valid_b), 64'd0);
        check("t4_end_hold", 64'(rd_data_b), 64'h303);

        // Test 5: DEPTH=300, address 310 is out of range.
        write_b(9'd310, 48'hDEAD);
        write_b(9'd299, 48'h299);
        read_b(9'd310, '0, "t5_oob");
        read_b(9'd54, '0, "t5_alias");
        read_b(9'd299, 48'h299, "t5_last");
        read_b(9'd1, 48'h101, "t5_keep");

        // Test 6: clear_req sweep, reset at sweep address 100, full restart.
        clear_req_a = 1'b1;
        tick();
        clear_req_a = 1'b0;
        check("t6_clr_busy", 64'(busy_a), 64'd1);
        re_a = 2'b01;
        rd_addr_a[AW-1:0] = 9'h011;
        tick();
        re_a = '0;
        check("t6_busy_rd_vld", 64'(rd_valid_a), 64'd0);
        check("t6_busy_rd_hold", 64'(rd_data_a[W-1:0]), 64'h1234_5678_9ABC);
        repeat (99) tick();
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(busy_a), 64'd1);
        check("t6_rst_vld", 64'(rd_valid_a), 64'd0);
        check("t6_rst_p0", 64'(rd_data_a[W-1:0]), 64'd0);
        check("t6_rst_p1", 64'(rd_data_a[W +: W]), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        count_sweep();
        check("t6_busy_cycles", 64'(n_a), 64'd512);
        read_a(0, 9'h010, '0, "t6_clear010");
        read_a(1, 9'h020, '0, "t6_clear020");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
